din_debouncer: RTL

Input conditioning stage between a raw, asynchronous, possibly bouncing `din` pin and the `either_edge_detector`. Synchronizes `din` into the `clk` domain through a flop chain. Accepts a level change only after it has held for a programmable number of enabled cycles. Drives a clean registered level `dout`, so the edge detector sees exactly one edge per accepted transition and none for glitches.

---
 rtl/din_debouncer.sv | 113 +++++++++++
 1 files changed

// File: rtl/din_debouncer.sv
// ----------------------------------------------------------------------------
// din_debouncer
//
// Conditions a raw, asynchronous, possibly bouncing input pin for use in the
// clk domain. The pin is first passed through a SYNC_STAGES-deep flop chain.
// A change of the synchronized level is accepted onto dout only after it has
// held for STABLE_CYCLES consecutive enabled cycles. A candidate change that
// collapses before then is dropped and reported with a one-cycle glitch pulse.
// Downstream edge detection therefore sees exactly one edge per accepted
// transition and none for bounces.
//
// Parameters
//   SYNC_STAGES    synchronizer depth (>= 2)
//   STABLE_CYCLES  enabled cycles a new level must hold before acceptance (>= 1)
//
// Ports
//   clk     in   single clock, rising edge
//   rst     in   synchronous reset, active low
//   din     in   raw asynchronous input
//   en      in   sample enable; low freezes the filter (synchronizer still runs)
//   dout    out  debounced level, registered
//   busy    out  high while a candidate change is being qualified
//   glitch  out  one-cycle pulse when a candidate change is rejected
// ----------------------------------------------------------------------------
module din_debouncer #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic en,
    output logic dout,
    output logic busy,
    output logic glitch
);

    // Counter width follows from STABLE_CYCLES; it is not meant to be set.
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    // Count value (one bit wider than the counter) at which a change is accepted.
    localparam logic [CNT_W:0] ACCEPT_AT = (CNT_W + 1)'(STABLE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_out;

    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic [CNT_W:0]         cnt_inc;
    logic                   dout_q;
    logic                   dout_d;
    logic                   glitch_q;
    logic                   glitch_d;

    // Synchronizer: always shifting, independent of en, so the filter sees a
    // current level the moment it is re-enabled.
    // NOTE: every flop here, including the synchronizer chain, is reset so
    // that busy and glitch cannot fire from stale history after reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so all
            // flops update together from values sampled at the same edge.
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign s_out   = sync_q[SYNC_STAGES-1];
    // Widened by one bit so the comparison against STABLE_CYCLES cannot wrap.
    assign cnt_inc = {1'b0, cnt_q} + 1'b1;

    // Filter next-state. cnt == 0 means the level is stable; any non-zero
    // count means a candidate change is being qualified.
    always_comb begin
        // NOTE: defaults first, so every path assigns every output and no
        // latch can be inferred.
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        glitch_d = 1'b0;

        if (en) begin
            if (s_out == dout_q) begin
                // Level went back before qualifying: drop the candidate.
                if (cnt_q != '0) begin
                    cnt_d    = '0;
                    glitch_d = 1'b1;
                end
            end else if (cnt_inc == ACCEPT_AT) begin
                dout_d = s_out;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_inc[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q    <= '0;
            dout_q   <= 1'b0;
            glitch_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            glitch_q <= glitch_d;
        end
    end

    assign dout   = dout_q;
    assign glitch = glitch_q;
    assign busy   = (cnt_q != '0);

endmodule
